rx_sync_scheduler: RTL and testbench

RX_SYNC_SCHEDULER -- requirements
Module: rx_sync_scheduler

---
 rtl/rx_sched_pkg.sv | 21 ++
 rtl/rx_rr_arbiter.sv | 36 +++
 rtl/rx_sync_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_rx_sync_scheduler.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_sched_pkg.sv
// Shared state encoding, sizing constants and helpers for the receiver sync scheduler.
package rx_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  localparam int BYTES_PER_SAMPLE = 6;
  localparam int MAX_NR           = 8;

  // Index of the lowest set bit; zero when the vector is empty.
  function automatic logic [2:0] lowest_index(input logic [MAX_NR-1:0] v);
    lowest_index = 3'd0;
    for (int k = MAX_NR - 1; k >= 0; k--) begin
      if (v[k]) lowest_index = 3'(k);
    end
  endfunction

endpackage

// File: rtl/rx_rr_arbiter.sv
// Combinational round-robin pick: first requester strictly above last_idx, wrapping to 0.
module rx_rr_arbiter #(
  parameter int NR = 4
) (
  input  logic [NR-1:0] req,
  input  logic [2:0]    last_idx,
  output logic [2:0]    grant_idx,
  output logic          grant_valid
);

  logic       found_hi;
  logic       found_lo;
  logic [2:0] idx_hi;
  logic [2:0] idx_lo;

  // Two passes: indices above the last grant take priority over the wrapped-around ones.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = 3'd0;
    idx_lo   = 3'd0;
    for (int n = 0; n < NR; n++) begin
      if (!found_hi && req[n] && (3'(n) > last_idx)) begin
        found_hi = 1'b1;
        idx_hi   = 3'(n);
      end
      if (!found_lo && req[n] && (3'(n) <= last_idx)) begin
        found_lo = 1'b1;
        idx_lo   = 3'(n);
      end
    end
    grant_valid = found_hi | found_lo;
    grant_idx   = found_hi ? idx_hi : idx_lo;
  end

endmodule

// File: rtl/rx_sync_scheduler.sv
// Round-robin receiver scheduler serialising 24-bit I/Q samples into a byte FIFO.
// Companion-receiver bundling is enabled by defining RX_SYNC_MUX_EN.
module rx_sync_scheduler #(
  parameter int NR = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [NR-1:0]    rx_rdy,
  input  logic [24*NR-1:0] rx_i,
  input  logic [24*NR-1:0] rx_q,
  input  logic [8*NR-1:0]  sync_mask,
  input  logic             fifo_full,
  output logic [NR-1:0]    rx_ack,
  output logic             wrenable,
  output logic [7:0]       data_out,
  output logic             fifo_clear,
  output logic [2:0]       cur_rx,
  output logic             busy
);

  import rx_sched_pkg::*;

  localparam logic [MAX_NR-1:0] VALID_MASK = MAX_NR'((1 << NR) - 1);

  state_t              state, state_nxt;
  logic [2:0]          last_grant, last_grant_nxt;
  logic [47:0]         shift_reg, shift_nxt;
  logic [2:0]          byte_cnt, byte_cnt_nxt;
  logic [MAX_NR-1:0]   pending, pending_nxt;
  logic [2:0]          src_idx, src_nxt;
  logic [NR-1:0]       rx_ack_nxt;
  logic                wrenable_nxt;
  logic [7:0]          data_out_nxt;
  logic                fifo_clear_nxt;
  logic [2:0]          cur_rx_nxt;
  logic                busy_nxt;

  logic [2:0]          arb_idx;
  logic                arb_valid;
  logic                grant_now;
  logic                last_byte;
  logic [2:0]          comp_idx;
  logic [2:0]          sel_idx;
  logic [23:0]         sel_i;
  logic [23:0]         sel_q;

  rx_rr_arbiter #(.NR(NR)) u_arbiter (
    .req         (rx_rdy),
    .last_idx    (last_grant),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  assign grant_now = !fifo_full && enable && arb_valid;
  assign last_byte = (byte_cnt == 3'(BYTES_PER_SAMPLE - 1));
  assign comp_idx  = lowest_index(pending);
  assign sel_idx   = (state == ST_IDLE) ? arb_idx : comp_idx;

  // One sample mux serves both the base grant and the companion reload.
  always_comb begin
    sel_i = '0;
    sel_q = '0;
    for (int n = 0; n < NR; n++) begin
      if (3'(n) == sel_idx) begin
        sel_i = rx_i[n*24 +: 24];
        sel_q = rx_q[n*24 +: 24];
      end
    end
  end

`ifdef RX_SYNC_MUX_EN
  logic [7:0] sel_mask;

  always_comb begin
    sel_mask = '0;
    for (int n = 0; n < NR; n++) begin
      if (3'(n) == arb_idx) sel_mask = sync_mask[n*8 +: 8];
    end
  end
`else
  logic unused_sync_mask;
  assign unused_sync_mask = ^sync_mask;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      last_grant <= 3'(NR - 1);
      shift_reg  <= '0;
      byte_cnt   <= '0;
      pending    <= '0;
      src_idx    <= '0;
      rx_ack     <= '0;
      wrenable   <= 1'b0;
      data_out   <= '0;
      fifo_clear <= 1'b0;
      cur_rx     <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      shift_reg  <= shift_nxt;
      byte_cnt   <= byte_cnt_nxt;
      pending    <= pending_nxt;
      src_idx    <= src_nxt;
      rx_ack     <= rx_ack_nxt;
      wrenable   <= wrenable_nxt;
      data_out   <= data_out_nxt;
      fifo_clear <= fifo_clear_nxt;
      cur_rx     <= cur_rx_nxt;
      busy       <= busy_nxt;
    end
  end

  // A full FIFO in IDLE always wins over a grant; SEND never looks at it.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (fifo_full)      state_nxt = ST_CLEAR;
        else if (grant_now) state_nxt = ST_SEND;
      end
      ST_SEND: begin
        if (last_byte && (pending == '0)) state_nxt = ST_IDLE;
      end
      ST_CLEAR: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    last_grant_nxt = last_grant;
    shift_nxt      = shift_reg;
    byte_cnt_nxt   = byte_cnt;
    pending_nxt    = pending;
    src_nxt        = src_idx;
    rx_ack_nxt     = '0;
    wrenable_nxt   = 1'b0;
    data_out_nxt   = data_out;
    fifo_clear_nxt = 1'b0;
    cur_rx_nxt     = cur_rx;
    busy_nxt       = (state_nxt != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (fifo_full) begin
          fifo_clear_nxt = 1'b1;
        end else if (grant_now) begin
          rx_ack_nxt     = NR'(1) << arb_idx;
          last_grant_nxt = arb_idx;
          src_nxt        = arb_idx;
          cur_rx_nxt     = arb_idx;
          shift_nxt      = {sel_i, sel_q};
          byte_cnt_nxt   = '0;
`ifdef RX_SYNC_MUX_EN
          pending_nxt    = sel_mask & ~(MAX_NR'(1) << arb_idx) & VALID_MASK;
`else
          pending_nxt    = '0;
`endif
        end
      end
      ST_SEND: begin
        wrenable_nxt = 1'b1;
        data_out_nxt = shift_reg[47:40];
        cur_rx_nxt   = src_idx;
        shift_nxt    = {shift_reg[39:0], 8'h00};
        byte_cnt_nxt = byte_cnt + 3'd1;
        // Companion data is loaded on the last byte so its first byte follows with no gap.
        if (last_byte) begin
          byte_cnt_nxt = '0;
          if (pending != '0) begin
            src_nxt     = comp_idx;
            pending_nxt = pending & ~(MAX_NR'(1) << comp_idx);
            shift_nxt   = {sel_i, sel_q};
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rx_sync_scheduler.sv
// Directed self-checking bench for rx_sync_scheduler (NR=4); honours RX_SYNC_MUX_EN.
module tb_rx_sync_scheduler;

  localparam int NR = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic             enable;
  logic [NR-1:0]    rx_rdy;
  logic [24*NR-1:0] rx_i;
  logic [24*NR-1:0] rx_q;
  logic [8*NR-1:0]  sync_mask;
  logic             fifo_full;
  logic [NR-1:0]    rx_ack;
  logic             wrenable;
  logic [7:0]       data_out;
  logic             fifo_clear;
  logic [2:0]       cur_rx;
  logic             busy;

  logic [23:0] ti [NR];
  logic [23:0] tq [NR];

  int n_compared = 0;
  int n_mismatch = 0;

  rx_sync_scheduler #(.NR(NR)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .rx_rdy     (rx_rdy),
    .rx_i       (rx_i),
    .rx_q       (rx_q),
    .sync_mask  (sync_mask),
    .fifo_full  (fifo_full),
    .rx_ack     (rx_ack),
    .wrenable   (wrenable),
    .data_out   (data_out),
    .fifo_clear (fifo_clear),
    .cur_rx     (cur_rx),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  always_comb begin
    rx_i = '0;
    rx_q = '0;
    for (int n = 0; n < NR; n++) begin
      rx_i[n*24 +: 24] = ti[n];
      rx_q[n*24 +: 24] = tq[n];
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic applyStimulus(input logic [NR-1:0] rdy, input logic en, input logic full);
    rx_rdy    = rdy;
    enable    = en;
    fifo_full = full;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatch++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Byte k (0 = I msb) of receiver r's sample, from the bench's own sample table.
  function automatic logic [7:0] exp_byte(input int r, input int k);
    logic [47:0] s;
    s = {ti[r], tq[r]};
    return s[47-8*k -: 8];
  endfunction

  initial begin
    int order [3];
    int rr [5];
    int nrec;
    order = '{0, 2, 3};
    rr    = '{0, 1, 2, 3, 0};

    ti[0] = 24'h123456; tq[0] = 24'hABCDEF;
    ti[1] = 24'h111213; tq[1] = 24'h141516;
    ti[2] = 24'h212223; tq[2] = 24'h242526;
    ti[3] = 24'h313233; tq[3] = 24'h343536;
    sync_mask = '0;
    reset = 1'b1;
    applyStimulus(4'b0000, 1'b1, 1'b0);
    tick(2);
    checkOutput("rst_wrenable", 64'(wrenable), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_fifo_clear", 64'(fifo_clear), 64'd0);
    checkOutput("rst_rx_ack", 64'(rx_ack), 64'd0);
    checkOutput("rst_cur_rx", 64'(cur_rx), 64'd0);
    checkOutput("rst_data_out", 64'(data_out), 64'd0);
    reset = 1'b0;

    // Single receiver, no companions
    applyStimulus(4'b0001, 1'b1, 1'b0);
    tick(1);
    checkOutput("single_ack", 64'(rx_ack), 64'h1);
    checkOutput("single_busy", 64'(busy), 64'd1);
    checkOutput("single_grant_wr", 64'(wrenable), 64'd0);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      tick(1);
      checkOutput($sformatf("single_wr%0d", k), 64'(wrenable), 64'd1);
      checkOutput($sformatf("single_byte%0d", k), 64'(data_out), 64'(exp_byte(0, k)));
      checkOutput($sformatf("single_ack_low%0d", k), 64'(rx_ack), 64'd0);
    end
    tick(1);
    checkOutput("single_end_wr", 64'(wrenable), 64'd0);
    checkOutput("single_end_busy", 64'(busy), 64'd0);

    // Companion bundling: mask 0x0D on receiver 0
    sync_mask = 32'h0000_000D;
`ifdef RX_SYNC_MUX_EN
    nrec = 3;
`else
    nrec = 1;
`endif
    applyStimulus(4'b0001, 1'b1, 1'b0);
    tick(1);
    checkOutput("sync_ack", 64'(rx_ack), 64'h1);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    for (int r = 0; r < nrec; r++) begin
      for (int k = 0; k < 6; k++) begin
        tick(1);
        checkOutput($sformatf("sync_wr_r%0d_b%0d", r, k), 64'(wrenable), 64'd1);
        checkOutput($sformatf("sync_byte_r%0d_b%0d", r, k), 64'(data_out), 64'(exp_byte(order[r], k)));
        checkOutput($sformatf("sync_cur_r%0d_b%0d", r, k), 64'(cur_rx), 64'(order[r]));
        checkOutput($sformatf("sync_noack_r%0d_b%0d", r, k), 64'(rx_ack), 64'd0);
      end
    end
    tick(1);
    checkOutput("sync_end_wr", 64'(wrenable), 64'd0);
    sync_mask = '0;

    // Round-robin with all receivers ready, starting after reset
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    applyStimulus(4'b1111, 1'b1, 1'b0);
    for (int g = 0; g < 5; g++) begin
      tick(1);
      checkOutput($sformatf("rr_ack%0d", g), 64'(rx_ack), 64'(1 << rr[g]));
      checkOutput($sformatf("rr_gap_wr%0d", g), 64'(wrenable), 64'd0);
      checkOutput($sformatf("rr_cur%0d", g), 64'(cur_rx), 64'(rr[g]));
      tick(6);
      checkOutput($sformatf("rr_last_byte%0d", g), 64'(data_out), 64'(exp_byte(rr[g], 5)));
      checkOutput($sformatf("rr_last_wr%0d", g), 64'(wrenable), 64'd1);
      checkOutput($sformatf("rr_idle%0d", g), 64'(busy), 64'd0);
    end
    applyStimulus(4'b0000, 1'b1, 1'b0);
    tick(1);
    checkOutput("rr_end_wr", 64'(wrenable), 64'd0);
    checkOutput("rr_end_ack", 64'(rx_ack), 64'd0);

    // FIFO full while idle
    applyStimulus(4'b0001, 1'b1, 1'b1);
    tick(1);
    checkOutput("clr_pulse", 64'(fifo_clear), 64'd1);
    checkOutput("clr_noack", 64'(rx_ack), 64'd0);
    checkOutput("clr_busy", 64'(busy), 64'd1);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    tick(1);
    checkOutput("clr_done", 64'(fifo_clear), 64'd0);
    checkOutput("clr_idle", 64'(busy), 64'd0);
    checkOutput("clr_done_noack", 64'(rx_ack), 64'd0);

    // FIFO full raised mid-record
    applyStimulus(4'b0001, 1'b1, 1'b0);
    tick(1);
    checkOutput("midfull_ack", 64'(rx_ack), 64'h1);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    tick(3);
    checkOutput("midfull_byte3", 64'(data_out), 64'(exp_byte(0, 2)));
    applyStimulus(4'b0000, 1'b1, 1'b1);
    tick(3);
    checkOutput("midfull_wr6", 64'(wrenable), 64'd1);
    checkOutput("midfull_byte6", 64'(data_out), 64'(exp_byte(0, 5)));
    checkOutput("midfull_noclr", 64'(fifo_clear), 64'd0);
    tick(1);
    checkOutput("midfull_clr", 64'(fifo_clear), 64'd1);
    checkOutput("midfull_clr_wr", 64'(wrenable), 64'd0);
    checkOutput("midfull_clr_ack", 64'(rx_ack), 64'd0);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    tick(1);
    checkOutput("midfull_clr_done", 64'(fifo_clear), 64'd0);
    checkOutput("midfull_idle", 64'(busy), 64'd0);

    // Reset mid-record aborts it and restores receiver 0 priority
    applyStimulus(4'b0010, 1'b1, 1'b0);
    tick(1);
    checkOutput("abort_ack", 64'(rx_ack), 64'h2);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    tick(4);
    checkOutput("abort_byte4", 64'(data_out), 64'(exp_byte(1, 3)));
    checkOutput("abort_cur", 64'(cur_rx), 64'd1);
    reset = 1'b1;
    tick(1);
    checkOutput("abort_wr", 64'(wrenable), 64'd0);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_cur_rst", 64'(cur_rx), 64'd0);
    reset = 1'b0;
    applyStimulus(4'b1111, 1'b1, 1'b0);
    tick(1);
    checkOutput("abort_regrant", 64'(rx_ack), 64'h1);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    tick(7);
    checkOutput("abort_regrant_end", 64'(wrenable), 64'd0);

    // Enable gating
    applyStimulus(4'b0010, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checkOutput($sformatf("en_off_ack%0d", i), 64'(rx_ack), 64'd0);
      checkOutput($sformatf("en_off_busy%0d", i), 64'(busy), 64'd0);
    end
    applyStimulus(4'b0010, 1'b1, 1'b0);
    tick(1);
    checkOutput("en_on_ack", 64'(rx_ack), 64'h2);
    applyStimulus(4'b0001, 1'b0, 1'b0);
    tick(6);
    checkOutput("en_drop_wr", 64'(wrenable), 64'd1);
    checkOutput("en_drop_byte", 64'(data_out), 64'(exp_byte(1, 5)));
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checkOutput($sformatf("en_drop_noack%0d", i), 64'(rx_ack), 64'd0);
      checkOutput($sformatf("en_drop_idle%0d", i), 64'(busy), 64'd0);
      checkOutput($sformatf("en_drop_nowr%0d", i), 64'(wrenable), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
